// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Entries pair an instruction word with the PC it was fetched from.
package if_fetch_pkg;
  localparam logic        RST_ENABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_fetch_fifo.sv
// Small power-of-2 queue of fetched {pc, inst} entries.
// Flush empties it in one cycle; pointers wrap naturally at DEPTH.
module if_fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, keeps one imem read in flight and
// hands buffered words to decode as isolated id_en pulses.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        id_en
);
  fetch_state_e                  state, state_nxt;
  logic [31:0]                   pc, req_pc;
  logic                          outstanding, issue, granted;
  logic                          q_push, q_pop, q_empty, q_full;
  logic [$clog2(FIFO_DEPTH):0]   q_count;
  fetch_entry_t                  q_head;

  assign outstanding = (state == ST_WAIT) || (state == ST_FLUSH);
  assign issue       = (state == ST_REQ) &&
                       (int'(q_count) + int'(outstanding) < FIFO_DEPTH);
  assign granted     = issue && imem_gnt_i;

  assign imem_req_o  = issue;
  // Address stays on the granted PC until its data returns.
  assign imem_addr_o = outstanding ? req_pc : pc;

  assign q_push = (state == ST_WAIT) && imem_rvalid_i && !redirect_i && !q_full;
  // The !id_en term forces a low cycle between pulses for decode's edge detect.
  assign q_pop  = !q_empty && !stall_i && !redirect_i && !id_en;

  if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_i),
    .wdata ('{pc: req_pc, inst: imem_rdata_i}),
    .rdata (q_head),
    .empty (q_empty),
    .full  (q_full),
    .count (q_count)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  state_nxt = ST_REQ;
      ST_REQ:   if (granted) state_nxt = redirect_i ? ST_FLUSH : ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid_i)   state_nxt = ST_REQ;
        else if (redirect_i) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: if (imem_rvalid_i) state_nxt = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= ST_IDLE;
      pc        <= PC_RESET;
      req_pc    <= PC_RESET;
      inst_o    <= ZERO_WORD;
      inst_pc_o <= ZERO_WORD;
      id_en     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect_i)   pc <= word_align(redirect_pc_i);
      else if (granted) pc <= pc + PC_STEP;
      if (granted) req_pc <= pc;
      id_en <= q_pop;
      if (q_pop) begin
        inst_o    <= q_head.inst;
        inst_pc_o <= q_head.pc;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: imem model, program-order scoreboard, directed
// corner cases followed by randomized stall/redirect traffic.
`timescale 1ns/1ps
module tb_if_fetch;
  logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req, gnt = 1'b0, rvalid = 1'b0, id_en;
  logic [31:0] addr, rdata = '0, inst, inst_pc;

  logic        rst2 = 1'b0, gnt2 = 1'b0, rv2 = 1'b0, req2, id2;
  logic [31:0] rdata2 = '0, addr2, inst2, ipc2;

  int checks = 0, passed = 0, pulses = 0;

  always #5 clk = ~clk;

  if_fetch #(.PC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(req), .imem_addr_o(addr),
    .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .inst_o(inst), .inst_pc_o(inst_pc), .id_en(id_en));

  if_fetch #(.PC_RESET(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .stall_i(1'b0), .redirect_i(1'b0),
    .redirect_pc_i(32'h0), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_gnt_i(gnt2), .imem_rvalid_i(rv2), .imem_rdata_i(rdata2),
    .inst_o(inst2), .inst_pc_o(ipc2), .id_en(id2));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Scoreboard: the program-order stream decode should see from the last restart point.
  logic [63:0] exp_q[$];
  logic [31:0] exp_tail;

  task automatic sb_refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({exp_tail, mem_word(exp_tail)});
      exp_tail = exp_tail + 32'd4;
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    exp_q.delete();
    exp_tail = start;
    sb_refill();
  endtask

  // Imem model: single pending read, random grant and latency, in-order data.
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0, gnt_pct = 100, lat_min = 1, lat_max = 1;
  logic [31:0] grants[$];

  task automatic imem_step();
    rvalid = 1'b0;
    gnt    = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        rvalid = 1'b1;
        rdata  = mem_word(pend_addr);
        pend   = 1'b0;
      end else pend_cnt--;
    end
    if (req && !pend && !rvalid && $urandom_range(99) < gnt_pct) begin
      gnt       = 1'b1;
      pend      = 1'b1;
      pend_addr = addr;
      pend_cnt  = $urandom_range(lat_max - 1, lat_min - 1);
      grants.push_back(addr);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    redirect = 1'b0;
    imem_step();
    sb_refill();
  endtask

  task automatic set_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    sb_restart({t[31:2], 2'b00});
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    sb_restart(32'h0);
    repeat (n) step();
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_id_en", {31'b0, id_en}, 32'h0);
    rst = 1'b1;
  endtask

  // Monitor: every handoff must be the next word in program order.
  logic        prev_id = 1'b0;
  logic [63:0] e;
  always @(negedge clk) begin
    if (rst) begin
      if (req) chk("addr_aligned", {30'b0, addr[1:0]}, 32'h0);
      if (id_en) begin
        pulses++;
        chk("id_en_gap", {31'b0, prev_id}, 32'h0);
        chk("id_en_blocked", {31'b0, stall | redirect}, 32'h0);
        if (exp_q.size() == 0) chk("sb_empty", 32'h1, 32'h0);
        else begin
          e = exp_q.pop_front();
          chk("handoff_pc", inst_pc, e[63:32]);
          chk("handoff_inst", inst, e[31:0]);
        end
      end
    end
    prev_id = id_en;
  end

  // Second instance: reset PC at the top of the address space.
  logic        p2 = 1'b0;
  logic [31:0] p2_addr = '0;
  logic [31:0] g2[$], pcs2[$];
  bit          done2 = 1'b0;
  initial begin
    repeat (3) @(negedge clk);
    #1 rst2 = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (id2) pcs2.push_back(ipc2);
      #1;
      rv2 = 1'b0;
      gnt2 = 1'b0;
      if (p2) begin
        rv2 = 1'b1;
        rdata2 = mem_word(p2_addr);
        p2 = 1'b0;
      end else if (req2) begin
        gnt2 = 1'b1;
        p2 = 1'b1;
        p2_addr = addr2;
        g2.push_back(addr2);
      end
    end
    gnt2 = 1'b0;
    rv2 = 1'b0;
    chk("wrap_ngrants", {31'b0, g2.size() >= 2}, 32'h1);
    chk("wrap_addr0", g2[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", g2[1], 32'h0000_0000);
    chk("wrap_npulses", {31'b0, pcs2.size() >= 2}, 32'h1);
    chk("wrap_pc0", pcs2[0], 32'hFFFF_FFFC);
    chk("wrap_pc1", pcs2[1], 32'h0000_0000);
    done2 = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  bit found;
  initial begin
    // Same-cycle grant, one-cycle data: addresses 0,4,8 and words in order.
    do_reset(4);
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    grants.delete(); pulses = 0;
    repeat (20) step();
    chk("t1_grant0", grants[0], 32'h0);
    chk("t1_grant1", grants[1], 32'h4);
    chk("t1_grant2", grants[2], 32'h8);
    chk("t1_pulses", {31'b0, pulses >= 2}, 32'h1);

    // Stall with imem always ready: queue fills with two words, request drops.
    do_reset(4);
    grants.delete();
    stall = 1'b1;
    repeat (10) step();
    chk("t2_grants", grants.size(), 32'd2);
    chk("t2_req_full", {31'b0, req}, 32'h0);
    stall = 1'b0; pulses = 0;
    repeat (10) step();
    chk("t2_pulses", {31'b0, pulses >= 2}, 32'h1);

    // Redirect while waiting for 0x8's data.
    do_reset(4);
    lat_min = 4; lat_max = 4;
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      step();
      if (pend && pend_addr == 32'h8 && pend_cnt == 2) begin
        set_redirect(32'h103);
        found = 1;
      end
    end
    chk("t3_setup", {31'b0, found}, 32'h1);
    grants.delete(); pulses = 0;
    repeat (30) step();
    chk("t3_next_addr", grants[0], 32'h100);
    chk("t3_pulses", {31'b0, pulses >= 1}, 32'h1);

    // Redirect coinciding with rvalid and a pending pop.
    do_reset(4);
    lat_min = 2; lat_max = 2;
    grants.delete();
    stall = 1'b1;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (rvalid && grants.size() == 2) begin
        stall = 1'b0;
        set_redirect(32'h200);
        found = 1;
      end
    end
    chk("t4_setup", {31'b0, found}, 32'h1);
    grants.delete(); pulses = 0;
    repeat (20) step();
    chk("t4_next_addr", grants[0], 32'h200);
    chk("t4_pulses", {31'b0, pulses >= 1}, 32'h1);

    // Reset during WAIT; the stale read returns after release.
    do_reset(4);
    lat_min = 6; lat_max = 6;
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      step();
      if (pend && pend_addr == 32'h4 && pend_cnt == 4) found = 1;
    end
    chk("t5_setup", {31'b0, found}, 32'h1);
    do_reset(2);
    grants.delete(); pulses = 0;
    repeat (40) step();
    chk("t5_first_addr", grants[0], 32'h0);
    chk("t5_pulses", {31'b0, pulses >= 1}, 32'h1);

    // Randomized traffic.
    do_reset(8);
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    pulses = 0;
    for (int c = 0; c < 800; c++) begin
      step();
      stall = ($urandom_range(99) < 30);
      if ($urandom_range(99) < 4) set_redirect($urandom());
    end
    stall = 1'b0;
    repeat (10) step();
    chk("rand_pulses", {31'b0, pulses >= 50}, 32'h1);

    for (int i = 0; i < 100 && !done2; i++) @(negedge clk);
    chk("wrap_done", {31'b0, done2}, 32'h1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
